// File: rtl/cpu_sequencer_pkg.sv
// Shared opcode/ALU encodings, sequencer state type and instruction field helpers
// for the multi-cycle fetch/decode/execute controller.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and imem (slave).
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 8
);

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);

endinterface

// File: rtl/cpu_sequencer_opcode_decoder.sv
// Pure combinational opcode map: ALU select plus ALU/halt classification.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_control,
  output logic       is_alu,
  output logic       is_halt
);

  always_comb begin
    alu_control = ALU_ADD;
    is_alu      = 1'b0;
    is_halt     = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_control = ALU_ADD; is_alu = 1'b1; end
      OP_SUB:  begin alu_control = ALU_SUB; is_alu = 1'b1; end
      OP_AND:  begin alu_control = ALU_AND; is_alu = 1'b1; end
      OP_OR:   begin alu_control = ALU_OR;  is_alu = 1'b1; end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns PC and IR, handshakes with
// instruction memory and sequences ALU control and register write enable.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  cpu_sequencer_if.master      imem,
  output logic [3:0]           rd_addr,
  output logic [3:0]           rs1_addr,
  output logic [3:0]           rs2_addr,
  output logic [2:0]           alu_control,
  output logic                 reg_write,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired_count
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;

  logic [3:0] dec_op;
  logic [2:0] dec_alu;
  logic       dec_is_alu;
  logic       dec_is_halt;

  // In FETCH the incoming word is decoded so alu_control can be registered on
  // the same edge that loads IR; afterwards the decoder looks at IR.
  assign dec_op = (state == S_FETCH) ? opcode_of(imem.rdata) : opcode_of(ir);

  opcode_decoder u_dec (
    .opcode      (dec_op),
    .alu_control (dec_alu),
    .is_alu      (dec_is_alu),
    .is_halt     (dec_is_halt)
  );

  assign imem.addr = pc;
  assign rd_addr   = ir[11:8];
  assign rs1_addr  = ir[7:4];
  assign rs2_addr  = ir[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      ir            <= '0;
      retired_count <= '0;
      imem.req      <= 1'b0;
      alu_control   <= '0;
      reg_write     <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state         <= S_FETCH;
            pc            <= '0;
            retired_count <= '0;
            imem.req      <= 1'b1;
            busy          <= 1'b1;
            halted        <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem.ready) begin
            state       <= S_DECODE;
            ir          <= imem.rdata;
            pc          <= pc + 1'b1;
            imem.req    <= 1'b0;
            alu_control <= dec_alu;
          end
        end
        S_DECODE: begin
          if (dec_is_halt) begin
            state       <= S_HALTED;
            alu_control <= '0;
            busy        <= 1'b0;
            halted      <= 1'b1;
          end else begin
            state     <= S_EXEC;
            reg_write <= dec_is_alu;
          end
        end
        S_EXEC: begin
          state       <= S_FETCH;
          reg_write   <= 1'b0;
          alu_control <= '0;
          imem.req    <= 1'b1;
          if (retired_count != '1) retired_count <= retired_count + 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          imem.req    <= 1'b0;
          alu_control <= '0;
          reg_write   <= 1'b0;
          busy        <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
